// File: rtl/reg_file_if.sv
// Register-file port bundle: one byte-enabled write port and two read ports.
interface reg_file_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH/8-1:0]   wbe;
    logic [AW-1:0]        raddr_a;
    logic [WIDTH-1:0]     rdata_a;
    logic [AW-1:0]        raddr_b;
    logic [WIDTH-1:0]     rdata_b;

    modport master (
        output we, waddr, wdata, wbe, raddr_a, raddr_b,
        input  rdata_a, rdata_b
    );

    modport slave (
        input  we, waddr, wdata, wbe, raddr_a, raddr_b,
        output rdata_a, rdata_b
    );
endinterface

// File: rtl/reg_file.sv
// General-purpose register bank: one synchronous byte-enabled write, two combinational reads.
// Optional macro REGFILE_BYPASS_EN forwards an accepted same-cycle write to the read ports.
module reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic        clk,
    input  logic        rst,
    reg_file_if.slave   bus
);
    localparam int NB = WIDTH / 8;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             write_ok;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    function automatic logic [WIDTH-1:0] merge_bytes(
        input logic [WIDTH-1:0] old_v,
        input logic [WIDTH-1:0] new_v,
        input logic [NB-1:0]    be
    );
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        end
        return res;
    endfunction

    // An address is live only if in range and not the hardwired zero entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!rst && addr_live(a)) begin
            v = mem[a];
`ifdef REGFILE_BYPASS_EN
            if (write_ok && (a == bus.waddr)) v = merge_bytes(v, bus.wdata, bus.wbe);
`endif
        end
        return v;
    endfunction

    assign write_ok = bus.we && !rst && addr_live(bus.waddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (write_ok) begin
            mem[bus.waddr] <= merge_bytes(mem[bus.waddr], bus.wdata, bus.wbe);
        end
    end

    always_comb begin
        rd_a = read_port(bus.raddr_a);
        rd_b = read_port(bus.raddr_b);
    end

    assign bus.rdata_a = rd_a;
    assign bus.rdata_b = rd_b;
endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file (DEPTH=24, ZERO_REG=1); expectations follow REGFILE_BYPASS_EN.
module tb_reg_file;
    logic clk;
    logic rst;
    logic sample;
    int   checks;
    int   passed;

    string       nm_q[$];
    logic [31:0] ea_q[$];
    logic [31:0] eb_q[$];

    reg_file_if #(.WIDTH(32), .AW(5)) bus ();

    reg_file #(.WIDTH(32), .DEPTH(24), .AW(5), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    // Monitor: pops one expectation whenever the stimulus presents a read.
    always @(negedge clk) begin
        if (sample) begin
            if (nm_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_sample: got empty queue required entry");
            end else begin
                string       nm;
                logic [31:0] ea;
                logic [31:0] eb;
                nm = nm_q.pop_front();
                ea = ea_q.pop_front();
                eb = eb_q.pop_front();
                checks++;
                if (bus.rdata_a === ea) passed++;
                else $display("FAIL %s port_a: got %h required %h", nm, bus.rdata_a, ea);
                checks++;
                if (bus.rdata_b === eb) passed++;
                else $display("FAIL %s port_b: got %h required %h", nm, bus.rdata_b, eb);
            end
        end
    end

    task automatic chk(input string nm, input logic [4:0] ra, input logic [4:0] rb,
                       input logic [31:0] ea, input logic [31:0] eb);
        bus.raddr_a = ra;
        bus.raddr_b = rb;
        nm_q.push_back(nm);
        ea_q.push_back(ea);
        eb_q.push_back(eb);
        sample = 1'b1;
        @(posedge clk);
        #1 sample = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        bus.wbe   = be;
        @(posedge clk);
        #1 bus.we = 1'b0;
    endtask

    logic [31:0] exp_same;
    logic [31:0] exp_part;

    initial begin
        checks = 0;
        passed = 0;
        sample = 1'b0;
        rst = 1'b1;
        bus.we = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.wbe = '0;
        bus.raddr_a = '0;
        bus.raddr_b = '0;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h12345678;
        exp_part = 32'h1234CCDD;
`else
        exp_same = 32'h0000AAAA;
        exp_part = 32'h12345678;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 5'd1, 5'd23, 32'h0, 32'h0);
        rst = 1'b0;

        for (int i = 1; i < 32; i++) wr(5'(i), 32'hDEADBEEF, 4'hF);
        chk("fill", 5'd1, 5'd23, 32'hDEADBEEF, 32'hDEADBEEF);
        chk("fill_oor", 5'd24, 5'd31, 32'h0, 32'h0);
        chk("fill_zero", 5'd0, 5'd12, 32'h0, 32'hDEADBEEF);

        // Reset between edges with a write pending across the next edge.
        bus.we = 1'b1;
        bus.waddr = 5'd4;
        bus.wdata = 32'hCAFEF00D;
        bus.wbe = 4'hF;
        rst = 1'b1;
        chk("rst_mid", 5'd1, 5'd23, 32'h0, 32'h0);
        rst = 1'b0;
        bus.we = 1'b0;
        chk("rst_after", 5'd4, 5'd1, 32'h0, 32'h0);

        wr(5'd5, 32'hBA09F533, 4'hF);
        wr(5'd6, 32'h7887BA09, 4'hF);
        chk("basic", 5'd5, 5'd6, 32'hBA09F533, 32'h7887BA09);
        chk("untouched", 5'd7, 5'd7, 32'h0, 32'h0);

        wr(5'd3, 32'h11223344, 4'hF);
        wr(5'd3, 32'hAABBCCDD, 4'b0101);
        chk("byte_en", 5'd3, 5'd3, 32'h11BB33DD, 32'h11BB33DD);
        wr(5'd3, 32'h00000000, 4'b0000);
        chk("wbe_zero", 5'd3, 5'd3, 32'h11BB33DD, 32'h11BB33DD);

        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        chk("zero_reg", 5'd0, 5'd5, 32'h0, 32'hBA09F533);
        wr(5'd30, 32'hFFFFFFFF, 4'hF);
        chk("oor_write", 5'd30, 5'd6, 32'h0, 32'h7887BA09);
        wr(5'd23, 32'h01020304, 4'hF);
        chk("top_entry", 5'd23, 5'd22, 32'h01020304, 32'h0);

        bus.wdata = 32'hFFFFFFFF;
        bus.waddr = 5'd5;
        bus.wbe = 4'hF;
        repeat (4) @(posedge clk);
        #1;
        chk("hold", 5'd5, 5'd6, 32'hBA09F533, 32'h7887BA09);

        wr(5'd9, 32'h0000AAAA, 4'hF);
        bus.we = 1'b1;
        bus.waddr = 5'd9;
        bus.wdata = 32'h12345678;
        bus.wbe = 4'hF;
        chk("same_cycle", 5'd9, 5'd9, exp_same, exp_same);
        bus.we = 1'b0;
        chk("after_write", 5'd9, 5'd9, 32'h12345678, 32'h12345678);

        bus.we = 1'b1;
        bus.wdata = 32'hAABBCCDD;
        bus.wbe = 4'b0011;
        chk("same_part", 5'd9, 5'd8, exp_part, 32'h0);
        bus.we = 1'b0;
        chk("part_after", 5'd9, 5'd9, 32'h1234CCDD, 32'h1234CCDD);

        bus.we = 1'b1;
        bus.waddr = 5'd0;
        bus.wdata = 32'hFFFFFFFF;
        bus.wbe = 4'hF;
        chk("same_zero", 5'd0, 5'd9, 32'h0, 32'h1234CCDD);
        bus.waddr = 5'd30;
        chk("same_oor", 5'd30, 5'd30, 32'h0, 32'h0);
        bus.we = 1'b0;

        for (int i = 0; i < 10 && nm_q.size() != 0; i++) @(posedge clk);
        if (nm_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending required 0", nm_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
